// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared ALU, one unified memory port with a
// req/ready handshake, and a control FSM taking 3-5 states per instruction.
// Ports:
//   clk, rst        clock, async active-high reset
//   mem_req/mem_we  memory request / write enable
//   mem_addr        byte address (PC on fetch, ALUOut on data access)
//   mem_wdata       store data (rt value latched in DECODE)
//   mem_rdata       read data, valid while mem_ready is high
//   mem_ready       access completes on a clock edge with mem_req && mem_ready
//   pc              current PC
//   illegal         sticky: unsupported instruction decoded, core halted
module mips_multicycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        illegal
);

    localparam int NREG = int'(REG_COUNT);
    localparam int RW   = $clog2(NREG);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_fn_t;

    state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] regs_q [NREG];

    logic          rf_we;
    logic [RW-1:0] rf_widx;
    logic [31:0]   rf_wdata;

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]   imm_sext;
    logic [31:0]   rf_a, rf_b;
    logic          funct_ok;

    logic [31:0] alu_a, alu_b, alu_y;
    alu_fn_t     alu_fn, r_fn;

    // Register indices always come from the latched IR.
    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RW];
    assign rt_idx   = ir_q[16 +: RW];
    assign rd_idx   = ir_q[11 +: RW];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    assign rf_a = (rs_idx == '0) ? '0 : regs_q[rs_idx];
    assign rf_b = (rt_idx == '0) ? '0 : regs_q[rt_idx];

    always_comb begin
        r_fn     = ALU_ADD;
        funct_ok = 1'b1;
        unique case (funct)
            6'h20:   r_fn = ALU_ADD;
            6'h22:   r_fn = ALU_SUB;
            6'h24:   r_fn = ALU_AND;
            6'h25:   r_fn = ALU_OR;
            6'h2A:   r_fn = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Shared ALU operand select: pc+4 in FETCH, branch target in DECODE.
    always_comb begin
        alu_a  = pc_q;
        alu_b  = 32'd4;
        alu_fn = ALU_ADD;
        unique case (state_q)
            S_DECODE: alu_b = {imm_sext[29:0], 2'b00};
            S_MEMADR, S_ADDIEX: begin
                alu_a = a_q;
                alu_b = imm_sext;
            end
            S_EXEC: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_fn = r_fn;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (alu_fn)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_widx  = rt_idx;
        rf_wdata = alu_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = alu_y;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf_a;
                b_d   = rf_b;
                alu_d = alu_y;
                unique case (1'b1)
                    (op == OP_LW || op == OP_SW): state_d = S_MEMADR;
                    (op == OP_R && funct_ok):     state_d = S_EXEC;
                    (op == OP_BEQ):               state_d = S_BRANCH;
                    (op == OP_ADDI):              state_d = S_ADDIEX;
                    (op == OP_J):                 state_d = S_JUMP;
                    default:                      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_d   = alu_y;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_d   = alu_y;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_widx = rd_idx;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = alu_y;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // $0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_widx != '0) begin
            regs_q[rf_widx] <= rf_wdata;
        end
    end

    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign illegal   = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed testbench for mips_multicycle with a wait-state memory model.
// Register results are observed through stores into the model memory.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    always #5 clk = ~clk;

    mips_multicycle #(.RESET_PC(32'h100), .REG_COUNT(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .illegal(illegal)
    );

    logic [31:0] rom [1024];
    logic [31:0] ram [1024];
    int          ram_ep [1024];
    int          epoch = 0;
    int          wait_r = 0, wait_w = 0;
    int          wcnt = 0, wr_cnt = 0, cyc = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [31:0] fe_pc [$];
    int          fe_cyc [$];
    logic        prev_f = 1'b0;
    logic        in_f;
    int          checks = 0, errors = 0;
    int          t0 = 0;

    // Store data of the current epoch overrides the loaded image.
    assign mem_rdata = (ram_ep[mem_addr[11:2]] == epoch) ?
                       ram[mem_addr[11:2]] : rom[mem_addr[11:2]];
    assign mem_ready = wcnt >= (mem_we ? wait_w : wait_r);
    assign in_f = !rst && mem_req && !mem_we && (mem_addr == pc);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) wcnt <= 0;
        else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (!rst && mem_req && mem_ready && mem_we) begin
            ram[mem_addr[11:2]]    <= mem_wdata;
            ram_ep[mem_addr[11:2]] <= epoch;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    // Log the cycle on which each fetch state is entered.
    always @(negedge clk) begin
        if (in_f && !prev_f) begin
            fe_pc.push_back(pc);
            fe_cyc.push_back(cyc);
        end
        prev_f <= in_f;
    end

    function automatic int entry_after(input logic [31:0] a, input int after);
        for (int i = 0; i < fe_pc.size(); i++)
            if (fe_cyc[i] > after && fe_pc[i] == a) return fe_cyc[i];
        return -1;
    endfunction

    function automatic int first(input logic [31:0] a);
        return entry_after(a, t0 - 1);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (ram_ep[a[11:2]] == epoch) ? ram[a[11:2]] : rom[a[11:2]];
    endfunction

    task automatic hold_reset();
        rst = 1'b1;
        epoch++;
        wait_r = 0;
        wait_w = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        rom[a[11:2]] = w;
    endtask

    // Returns at the first negedge after release, core in FETCH of RESET_PC.
    task automatic release_reset();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        put(32'h100, 32'h2001_0005);
        put(32'h104, 32'h1000_FFFF);
        repeat (2) @(negedge clk);
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got %h want 100", mem_addr); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b want 1", mem_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc got %h want 100", pc); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", illegal); end
        release_reset();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rel_pc0 got %h want 100", pc); end
        @(negedge clk);
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL rel_pc1 got %h want 104", pc); end
    endtask

    task automatic test_alu();
        int c0;
        hold_reset();
        put(32'h100, 32'h2001_0005);
        put(32'h104, 32'h2002_FFFD);
        put(32'h108, 32'h0022_1820);
        put(32'h10C, 32'h0041_2022);
        put(32'h110, 32'h0041_282A);
        put(32'h114, 32'hAC03_0080);
        put(32'h118, 32'hAC04_0084);
        put(32'h11C, 32'hAC05_0088);
        put(32'h120, 32'h1000_FFFF);
        release_reset();
        repeat (60) @(negedge clk);
        c0 = first(32'h100);
        checks++; if (mem_rd(32'h80) !== 32'h2) begin errors++; $display("FAIL add got %h want 2", mem_rd(32'h80)); end
        checks++; if (mem_rd(32'h84) !== 32'hFFFF_FFF8) begin errors++; $display("FAIL sub got %h want fffffff8", mem_rd(32'h84)); end
        checks++; if (mem_rd(32'h88) !== 32'h1) begin errors++; $display("FAIL slt got %h want 1", mem_rd(32'h88)); end
        checks++; if (first(32'h114) - c0 !== 20) begin errors++; $display("FAIL alu_total got %0d want 20", first(32'h114) - c0); end
        checks++; if (first(32'h104) - c0 !== 4) begin errors++; $display("FAIL addi_cpi got %0d want 4", first(32'h104) - c0); end
        checks++; if (first(32'h118) - first(32'h114) !== 4) begin errors++; $display("FAIL sw_cpi got %0d want 4", first(32'h118) - first(32'h114)); end
    endtask

    task automatic test_load_store();
        int base, stable, n;
        logic bad;
        hold_reset();
        put(32'h100, 32'h2003_0002);
        put(32'h104, 32'hAC03_0008);
        put(32'h108, 32'h8C06_0008);
        put(32'h10C, 32'hAC06_0090);
        put(32'h110, 32'h1000_FFFF);
        put(32'h008, 32'hCAFE_0000);
        wait_w = 2;
        release_reset();
        base = wr_cnt; stable = 0; n = 0; bad = 1'b0;
        while (wr_cnt == base && n < 60) begin
            if (mem_we) begin
                stable++;
                if (mem_addr !== 32'h8 || mem_wdata !== 32'h2) bad = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        wait_r = 2;
        checks++; if (wr_cnt == base) begin errors++; $display("FAIL sw_timeout got no write want write"); end
        checks++; if (wr_addr !== 32'h8) begin errors++; $display("FAIL sw_addr got %h want 8", wr_addr); end
        checks++; if (wr_data !== 32'h2) begin errors++; $display("FAIL sw_data got %h want 2", wr_data); end
        checks++; if (stable !== 3) begin errors++; $display("FAIL sw_hold got %0d want 3", stable); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL sw_stable got %b want 0", bad); end
        repeat (40) @(negedge clk);
        checks++; if (mem_rd(32'h90) !== 32'h2) begin errors++; $display("FAIL lw_val got %h want 2", mem_rd(32'h90)); end
        checks++; if (first(32'h108) - first(32'h104) !== 6) begin errors++; $display("FAIL sw_wait_cpi got %0d want 6", first(32'h108) - first(32'h104)); end
        checks++; if (first(32'h10C) - first(32'h108) !== 9) begin errors++; $display("FAIL lw_wait_cpi got %0d want 9", first(32'h10C) - first(32'h108)); end
    endtask

    task automatic test_control();
        int tj;
        hold_reset();
        put(32'h100, 32'h2001_0005);
        put(32'h104, 32'h2002_FFFD);
        put(32'h108, 32'h2000_0007);
        put(32'h10C, 32'h1021_0002);
        put(32'h110, 32'hAC01_00A0);
        put(32'h114, 32'hAC02_00A4);
        put(32'h118, 32'h1022_0005);
        put(32'h11C, 32'hAC00_00A8);
        put(32'h120, 32'h0800_0040);
        put(32'h0A0, 32'h1234_5678);
        put(32'h0A4, 32'h8765_4321);
        put(32'h0A8, 32'hDEAD_BEEF);
        release_reset();
        repeat (40) @(negedge clk);
        tj = first(32'h120);
        checks++; if (first(32'h118) - first(32'h10C) !== 3) begin errors++; $display("FAIL beq_taken got %0d want 3", first(32'h118) - first(32'h10C)); end
        checks++; if (first(32'h110) !== -1) begin errors++; $display("FAIL beq_skip got %0d want -1", first(32'h110)); end
        checks++; if (first(32'h11C) - first(32'h118) !== 3) begin errors++; $display("FAIL beq_fall got %0d want 3", first(32'h11C) - first(32'h118)); end
        checks++; if (mem_rd(32'hA8) !== 32'h0) begin errors++; $display("FAIL r0_write got %h want 0", mem_rd(32'hA8)); end
        checks++; if (mem_rd(32'hA0) !== 32'h1234_5678) begin errors++; $display("FAIL skipped_sw got %h want 12345678", mem_rd(32'hA0)); end
        checks++; if (entry_after(32'h100, tj) - tj !== 3) begin errors++; $display("FAIL jump got %0d want 3", entry_after(32'h100, tj) - tj); end
    endtask

    task automatic test_illegal();
        hold_reset();
        put(32'h100, 32'h0800_0008);
        put(32'h020, 32'hFC00_0000);
        release_reset();
        repeat (4) @(negedge clk);
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL ill_pc_dec got %h want 24", pc); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_early got %b want 0", illegal); end
        @(negedge clk);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ill_req got %b want 0", mem_req); end
        repeat (20) @(negedge clk);
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL ill_pc_hold got %h want 24", pc); end
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ill_sticky got %b/%b want 1/0", illegal, mem_req); end
        rst = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", illegal); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL ill_rst_pc got %h want 100", pc); end
    endtask

    task automatic test_reset_store();
        int base;
        hold_reset();
        put(32'h100, 32'h2001_0055);
        put(32'h104, 32'hAC01_00B0);
        put(32'h108, 32'h1000_FFFF);
        put(32'h0B0, 32'h7777_7777);
        wait_w = 1000;
        release_reset();
        base = wr_cnt;
        repeat (7) @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'hB0) begin errors++; $display("FAIL mw_state got %b/%h want 1/b0", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'h55) begin errors++; $display("FAIL mw_data got %h want 55", mem_wdata); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mr_we got %b want 0", mem_we); end
        checks++; if (pc !== 32'h100 || mem_addr !== 32'h100) begin errors++; $display("FAIL mr_pc got %h/%h want 100/100", pc, mem_addr); end
        checks++; if (mem_req !== 1'b1 || mem_wdata !== 32'h0) begin errors++; $display("FAIL mr_port got %b/%h want 1/0", mem_req, mem_wdata); end
        repeat (3) @(negedge clk);
        checks++; if (wr_cnt !== base) begin errors++; $display("FAIL mr_nowrite got %0d want %0d", wr_cnt, base); end
        checks++; if (mem_rd(32'hB0) !== 32'h7777_7777) begin errors++; $display("FAIL mr_mem got %h want 77777777", mem_rd(32'hB0)); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_control();
        test_illegal();
        test_reset_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS core, the parametrised successor to the single-cycle core. It executes one instruction over 3–5 states of a control FSM. It shares one ALU and one unified instruction/data memory port, and that port has a request/ready handshake, so slow memories insert wait states. It sits between the top-level testbench or SoC wrapper and a single memory model, replacing the split instruction/data ports of the single-cycle design.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- REG_COUNT, 32: number of architectural registers (power of two, 8..32); register index uses the low log2(REG_COUNT) bits of rs/rt/rd.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory access request; asserted in FETCH, MEMRD, MEMWR.
- mem_we  out  1  write enable; 1 only in MEMWR.
- mem_addr  out  32  byte address; PC in FETCH, ALU address register in MEMRD/MEMWR.
- mem_wdata  out  32  store data, the rt register value latched in DECODE.
- mem_rdata  in  32  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  access completes at the rising edge where mem_req && mem_ready.
- pc  out  32  current PC.
- illegal  out  1  sticky flag: an unsupported opcode/funct was decoded and the core halted.

## Operation
- Supported instructions: R-type add, sub, and, or, slt (op 0, funct 20/22/24/25/2A hex), lw (23), sw (2B), beq (04), addi (08), j (02). Everything else is illegal.
- FSM states and transitions:
  - FETCH. Wait while !mem_ready. On ready: IR ← mem_rdata, pc ← pc+4, go to DECODE.
  - DECODE. Read rs/rt into A/B. ALUOut ← pc + (sext(imm)<<2), the branch target. Dispatch by opcode: lw/sw→MEMADR; R→EXEC; beq→BRANCH; addi→ADDIEX; j→JUMP; illegal→HALT.
  - MEMADR. ALUOut ← A + sext(imm). lw→MEMRD, sw→MEMWR.
  - MEMRD. Wait for ready. Then MDR ← mem_rdata and go to MEMWB.
  - MEMWB. rt ← MDR, then FETCH.
  - MEMWR. Wait for ready, then FETCH.
  - EXEC. ALUOut ← A op B, then ALUWB.
  - ALUWB. rd ← ALUOut, then FETCH.
  - ADDIEX. ALUOut ← A + sext(imm), then ADDIWB.
  - ADDIWB. rt ← ALUOut, then FETCH.
  - BRANCH. If A==B, pc ← ALUOut. Then FETCH.
  - JUMP. pc ← {pc[31:28], instr_index, 2'b00}, then FETCH.
  - HALT. Terminal. illegal=1, mem_req=0, pc frozen. Only rst exits.
- Arithmetic: all 32-bit modulo 2^32, with no overflow trap (add/addi behave as addu/addiu). slt is a signed compare that yields 32'd1 or 32'd0. Immediates are sign-extended.
- Register 0 reads as 0. Writes to it are discarded.
- Writes use the index as captured in IR, not the live bus.

## Timing
- Base CPI with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, counting cycles from FETCH entry to the next FETCH entry.
- Each low cycle of mem_ready in FETCH/MEMRD/MEMWR adds exactly one cycle.
- While waiting, mem_addr, mem_we and mem_wdata are held stable and no architectural state changes.
- Reset, asynchronous, while rst is high:
  - pc=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, all registers=0, illegal=0.
  - Consequently mem_req=1, mem_we=0, mem_addr=RESET_PC, mem_wdata=0.
  - mem_ready is ignored during reset.
- Reset mid-operation: the in-flight instruction is abandoned.
  - A pending store is dropped, since mem_we falls with the async reset.
  - Register writes scheduled for the same edge as reset assertion do not happen.
- Fetch of the first instruction completes at the first rising edge after rst deasserts at which mem_ready=1.
- beq where the target equals the fall-through pc+4 behaves like a not-taken branch. A branch to itself (offset −1) loops with CPI 3.
- PC wraps from FFFF_FFFC to 0000_0000 without a flag.

## Test plan
- Reset and fetch: hold rst 3 cycles with RESET_PC=32'h100.
  - During reset: mem_addr=100, mem_req=1, pc=100.
  - After release with ready=1: pc=104 one cycle later.
- ALU program, zero-wait memory: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1.
  - Required: $3=2, $4=FFFF_FFF8, $5=1.
  - Total 20 cycles.
- Load/store with 2 wait states per access: sw $3,8($0) then lw $6,8($0).
  - Required: write at addr 8, data 2, addr/data stable for 3 cycles.
  - $6=2. sw takes 6 cycles, lw takes 9.
- Control flow:
  - beq $1,$1,+2 skips two instructions, total 3 cycles.
  - beq $1,$2 not taken falls through.
  - j 0x40 sets pc=0x100 after 3 cycles.
  - Writing $0 via addi $0,$0,7 leaves $0=0.
- Illegal: opcode 3F at pc 0x20 → illegal=1 on the cycle after DECODE, mem_req=0, pc stays 0x24 indefinitely. rst clears it.
- Reset mid-store: assert rst in MEMWR with ready=0 → mem_we drops immediately, no write occurs, pc=RESET_PC.
